// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
// Optional trap support is enabled with the PC_SEQ_TRAP_EN macro.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_SEQ    = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_JUMP   = 3'd3,
    SEL_JREG   = 3'd4,
    SEL_TRAP   = 3'd5,
    SEL_ERET   = 3'd6
  } npc_sel_t;

  localparam logic [31:0] PC_INC               = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0180;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-pc calculation: candidate targets plus priority select.
// Trap/eret candidates exist only when PC_SEQ_TRAP_EN is defined.
module pc_target_calc
  import pc_seq_pkg::*;
`ifdef PC_SEQ_TRAP_EN
#(
  parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
)
`endif
(
  input  logic [31:0] pc,
  input  logic        halt,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_addr,
`ifdef PC_SEQ_TRAP_EN
  input  logic        trap,
  input  logic        eret,
  input  logic [31:0] epc,
`endif
  output npc_sel_t    sel,
  output logic [31:0] pc4,
  output logic [31:0] next_pc
);

  logic [31:0] branch_pc;
  logic [31:0] jump_pc;
  logic [31:0] jreg_pc;

  assign pc4       = pc + PC_INC;
  assign branch_pc = pc4 + (branch_offset << 2);
  assign jump_pc   = {pc4[31:28], jump_target, 2'b00};
  assign jreg_pc   = jr_addr & 32'hFFFF_FFFC;

  // Priority select; halt and stall both keep the current pc.
  always_comb begin
    sel = SEL_SEQ;
    if (halt || stall)      sel = SEL_HOLD;
`ifdef PC_SEQ_TRAP_EN
    else if (trap)          sel = SEL_TRAP;
    else if (eret)          sel = SEL_ERET;
`endif
    else if (jump_reg)      sel = SEL_JREG;
    else if (jump)          sel = SEL_JUMP;
    else if (branch_taken)  sel = SEL_BRANCH;
  end

  // Mux the selected candidate.
  always_comb begin
    next_pc = pc4;
    case (sel)
      SEL_HOLD:   next_pc = pc;
      SEL_SEQ:    next_pc = pc4;
      SEL_BRANCH: next_pc = branch_pc;
      SEL_JUMP:   next_pc = jump_pc;
      SEL_JREG:   next_pc = jreg_pc;
`ifdef PC_SEQ_TRAP_EN
      SEL_TRAP:   next_pc = TRAP_VECTOR;
      SEL_ERET:   next_pc = epc;
`endif
      default:    next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: fetch/exec/halt FSM with redirect handling.
// Optional trap/eret support and the epc register: PC_SEQ_TRAP_EN.
//
// state  | meaning
// FETCH  | imem_req high, waiting for imem_ready; pc stable
// EXEC   | instruction at pc executing; redirect inputs sampled
// HALTED | fetching stopped until reset
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_addr,
  input  logic        stall,
  input  logic        halt,
`ifdef PC_SEQ_TRAP_EN
  input  logic        trap,
  input  logic        eret,
  output logic [31:0] epc,
`endif
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        pc_valid,
  output logic        halted
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  npc_sel_t    sel;
  logic [31:0] pc4;
  logic [31:0] next_pc;

`ifdef PC_SEQ_TRAP_EN
  logic [31:0] epc_q, epc_d;
`else
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;
`endif

  pc_target_calc
`ifdef PC_SEQ_TRAP_EN
    #(.TRAP_VECTOR(TRAP_VECTOR))
`endif
  u_calc (
    .pc            (pc_q),
    .halt          (halt),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .jump_reg      (jump_reg),
    .jr_addr       (jr_addr),
`ifdef PC_SEQ_TRAP_EN
    .trap          (trap),
    .eret          (eret),
    .epc           (epc_q),
`endif
    .sel           (sel),
    .pc4           (pc4),
    .next_pc       (next_pc)
  );

  // Next-state, next-pc and Moore outputs.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
`ifdef PC_SEQ_TRAP_EN
    epc_d    = epc_q;
`endif
    imem_req = 1'b0;
    pc_valid = 1'b0;
    halted   = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_d = EXEC;
      end
      EXEC: begin
        pc_valid = 1'b1;
        if (halt) begin
          state_d = HALTED;
        end else if (!stall) begin
          pc_d    = next_pc;
          state_d = FETCH;
`ifdef PC_SEQ_TRAP_EN
          if (sel == SEL_TRAP) epc_d = pc4;
`endif
        end
      end
      HALTED: begin
        halted = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State and pc registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_VECTOR;
`ifdef PC_SEQ_TRAP_EN
      epc_q   <= 32'h0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef PC_SEQ_TRAP_EN
      epc_q   <= epc_d;
`endif
    end
  end

  assign pc = pc_q;
`ifdef PC_SEQ_TRAP_EN
  assign epc = epc_q;
`endif

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0180: trap handler entry address; used only when PC_SEQ_TRAP_EN is defined.
REQ-003 Clock  in  1  system clock; one clock, all state updates on its rising edge.
REQ-004 Reset  in  1  reset; synchronous, active-high.
REQ-005 imem_ready  in  1  instruction memory returns the word for the current pc this cycle.
REQ-006 branch_taken  in  1  conditional branch resolved taken.
REQ-007 branch_offset  in  32  sign-extended word offset.
REQ-008 jump  in  1  absolute jump.
REQ-009 jump_target  in  26  jump index field.
REQ-010 jump_reg  in  1  register-indirect jump.
REQ-011 jr_addr  in  32  register jump address.
REQ-012 stall  in  1  hold the current instruction in EXEC.
REQ-013 halt  in  1  stop fetching.
REQ-014 trap, eret  in  1 each  exception entry and return; present only with PC_SEQ_TRAP_EN.
REQ-015 pc  out  32  current fetch address.
REQ-016 imem_req  out  1  fetch request.
REQ-017 pc_valid  out  1  instruction at pc is executing; redirect inputs are sampled only in this cycle.
REQ-018 halted  out  1  sequencer is in HALTED.
REQ-019 epc  out  32  saved return address; present only with PC_SEQ_TRAP_EN.

Function
REQ-020 FSM states and transitions:
- FETCH: imem_req=1; moves to EXEC when imem_ready=1, otherwise stays.
- EXEC: pc_valid=1; returns to FETCH after loading the next pc.
- HALTED: imem_req=0, pc_valid=0, halted=1.
REQ-021 Handshake: pc is stable while imem_req=1; imem_ready is ignored outside FETCH.
REQ-022 EXEC priority order: halt > stall > trap > eret > jump_reg > jump > branch_taken > sequential.
REQ-023 EXEC with halt=1: go to HALTED with pc unchanged; stay there until Reset.
REQ-024 EXEC with stall=1 and halt=0: stay in EXEC, pc held, pc_valid stays 1; redirect inputs are re-sampled in the first non-stall cycle.
REQ-025 Next-pc sources (pc4 = pc+4, all arithmetic modulo 2^32, wrap at 32'hFFFF_FFFC to 0):
- sequential: pc4.
- branch: pc4 + (branch_offset<<2).
- jump: {pc4[31:28], jump_target, 2'b00}.
- jump_reg: {jr_addr[31:2], 2'b00}; low bits are silently forced to 0.
REQ-026 When several redirects are asserted together, only the highest-priority one takes effect and the rest are ignored.
REQ-027 Latency: the new pc is visible and imem_req=1 in the cycle after the EXEC cycle.

Reset
REQ-028 Reset (sampled high on a Clock edge) has priority over all other inputs in any state, including mid-fetch and HALTED: state=FETCH, pc=RESET_VECTOR, epc=0.
REQ-029 Output values in the cycle after that edge: imem_req=1, pc_valid=0, halted=0.

Configuration
REQ-030 With PC_SEQ_TRAP_EN defined:
- trap in EXEC sets epc=pc4 and pc=TRAP_VECTOR.
- eret in EXEC sets pc=epc.
- trap and eret are simultaneously asserted: trap wins.
REQ-031 Without PC_SEQ_TRAP_EN: the trap, eret and epc ports and the epc register do not exist, and the priority order omits both.

Structure
REQ-032 Shared package pc_seq_pkg holds:
- the state enum (FETCH, EXEC, HALTED);
- the next-pc select enum;
- the PC increment constant 4;
- the default vectors.
REQ-033 Sub-module pc_target_calc is purely combinational: it computes all candidate targets and the priority select. The FSM and registers stay in pc_sequencer.

Verification
REQ-034 Reset with imem_ready tied 1 -> pc runs 0,4,8,… with pc_valid alternating 0/1 each cycle.
REQ-035 At pc=0x100 in EXEC, branch_taken=1 and branch_offset=-2 -> next pc=0xFC; with jump=1 also asserted in the same cycle -> next pc={0x0,jump_target,00}.
REQ-036 jump_reg=1 with jr_addr=0x1003 -> pc=0x1000; at pc=0xFFFF_FFFC, sequential step -> pc=0.
REQ-037 imem_ready held 0 for 3 cycles -> pc and imem_req held for 3 cycles; stall=1 for 2 cycles in EXEC -> pc_valid high 3 cycles, pc held.
REQ-038 halt=1 in EXEC at pc=0x40 -> halted=1, pc=0x40 held; Reset asserted later -> pc=RESET_VECTOR, halted=0.
REQ-039 (PC_SEQ_TRAP_EN) trap at pc=0x200 -> pc=0x180, epc=0x204; later eret -> pc=0x204; Reset asserted mid-FETCH -> epc=0.
